// File: rtl/mbf_stream_checker.sv
// Self-checking output scoreboard for the MBF filter family: compares NCH sample streams
// against preloaded expected memories. Define MBF_CHK_FIRSTERR_EN to add first-mismatch capture.
module mbf_stream_checker #(
   parameter int NCH     = 2,
   parameter int DW      = 8,
   parameter int N_EXP   = 527,
   parameter int AW      = 10,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 10000000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [NCH-1:0]       in_valid,
   input  logic [NCH*DW-1:0]    in_data,
   input  logic                 ld_en,
   input  logic [2:0]           ld_ch,
   input  logic [AW-1:0]        ld_addr,
   input  logic [DW-1:0]        ld_data,
   output logic                 busy,
   output logic [NCH-1:0]       ch_done,
   output logic                 all_done,
   output logic                 timed_out,
   output logic                 pass,
   output logic [NCH*CNT_W-1:0] err_cnt,
   output logic [NCH*CNT_W-1:0] pass_cnt
`ifdef MBF_CHK_FIRSTERR_EN
   ,
   output logic                 first_err_vld,
   output logic [2:0]           first_err_ch,
   output logic [AW-1:0]        first_err_idx,
   output logic [DW-1:0]        first_err_got,
   output logic [DW-1:0]        first_err_exp
`endif
);

   localparam int IW  = (N_EXP > 1) ? $clog2(N_EXP) : 1;
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int TW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_TMO} state_t;

   state_t        state;
   logic [DW-1:0] exp_mem  [NCH][N_EXP];
   logic [DW-1:0] exp_word [NCH];
   logic [AW-1:0] idx      [NCH];
   logic [TW-1:0] cyc;
   logic [NCH-1:0] hit;
   logic [NCH-1:0] miss;
   logic          ld_ok;

   always_comb begin
      ld_ok = ld_en && (state != S_RUN) && (int'(ld_ch) < NCH) && (int'(ld_addr) < N_EXP);
   end

   // NOTE: the expected memory has no reset on purpose; it must survive a mid-run abort,
   // and leaving it out of the reset network lets it map onto block RAM.
   always_ff @(posedge clk) begin
      if (ld_ok) exp_mem[ld_ch[CHW-1:0]][ld_addr[IW-1:0]] <= ld_data;
   end

   // Combinational read keeps the compare in the same cycle as the sample strobe.
   always_comb begin
      // NOTE: every signal gets a default at the top of an always_comb so no path
      // leaves it unassigned and no latch is inferred.
      hit  = '0;
      miss = '0;
      for (int c = 0; c < NCH; c++) begin
         exp_word[c] = exp_mem[c][idx[c][IW-1:0]];
         hit[c]      = (state == S_RUN) && in_valid[c] && !ch_done[c];
         miss[c]     = hit[c] && (in_data[c*DW +: DW] != exp_word[c]);
      end
   end

`ifdef MBF_CHK_FIRSTERR_EN
   logic          fe_hit;
   logic [2:0]    fe_ch;
   logic [AW-1:0] fe_idx;
   logic [DW-1:0] fe_got;
   logic [DW-1:0] fe_exp;

   // Descending scan so the lowest mismatching channel is the one left selected.
   always_comb begin
      fe_hit = |miss;
      fe_ch  = '0;
      fe_idx = '0;
      fe_got = '0;
      fe_exp = '0;
      for (int c = NCH - 1; c >= 0; c--) begin
         if (miss[c]) begin
            fe_ch  = 3'(c);
            fe_idx = idx[c];
            fe_got = in_data[c*DW +: DW];
            fe_exp = exp_word[c];
         end
      end
   end
`endif

   // NOTE: all state here uses non-blocking assignments so every register samples
   // values from before the edge, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         ch_done   <= '0;
         all_done  <= 1'b0;
         timed_out <= 1'b0;
         pass      <= 1'b0;
         err_cnt   <= '0;
         pass_cnt  <= '0;
         cyc       <= '0;
         for (int c = 0; c < NCH; c++) idx[c] <= '0;
`ifdef MBF_CHK_FIRSTERR_EN
         first_err_vld <= 1'b0;
         first_err_ch  <= '0;
         first_err_idx <= '0;
         first_err_got <= '0;
         first_err_exp <= '0;
`endif
      end else begin
         case (state)
            S_RUN: begin
               for (int c = 0; c < NCH; c++) begin
                  if (hit[c]) begin
                     if (miss[c]) begin
                        if (err_cnt[c*CNT_W +: CNT_W] != {CNT_W{1'b1}})
                           err_cnt[c*CNT_W +: CNT_W] <= err_cnt[c*CNT_W +: CNT_W] + CNT_W'(1);
                     end else begin
                        if (pass_cnt[c*CNT_W +: CNT_W] != {CNT_W{1'b1}})
                           pass_cnt[c*CNT_W +: CNT_W] <= pass_cnt[c*CNT_W +: CNT_W] + CNT_W'(1);
                     end
                     if (idx[c] == AW'(N_EXP - 1)) ch_done[c] <= 1'b1;
                     else                          idx[c]     <= idx[c] + AW'(1);
                  end
               end
`ifdef MBF_CHK_FIRSTERR_EN
               if (fe_hit && !first_err_vld) begin
                  first_err_vld <= 1'b1;
                  first_err_ch  <= fe_ch;
                  first_err_idx <= fe_idx;
                  first_err_got <= fe_got;
                  first_err_exp <= fe_exp;
               end
`endif
               // Completion is tested first so it wins a tie with the timeout.
               if (&ch_done) begin
                  state    <= S_DONE;
                  busy     <= 1'b0;
                  all_done <= 1'b1;
                  pass     <= (err_cnt == '0);
               end else if (cyc == TW'(TIMEOUT - 1)) begin
                  state     <= S_TMO;
                  busy      <= 1'b0;
                  timed_out <= 1'b1;
               end else begin
                  cyc <= cyc + TW'(1);
               end
            end
            default: begin
               if (start) begin
                  state     <= S_RUN;
                  busy      <= 1'b1;
                  ch_done   <= '0;
                  all_done  <= 1'b0;
                  timed_out <= 1'b0;
                  pass      <= 1'b0;
                  err_cnt   <= '0;
                  pass_cnt  <= '0;
                  cyc       <= '0;
                  for (int c = 0; c < NCH; c++) idx[c] <= '0;
`ifdef MBF_CHK_FIRSTERR_EN
                  first_err_vld <= 1'b0;
                  first_err_ch  <= '0;
                  first_err_idx <= '0;
                  first_err_got <= '0;
                  first_err_exp <= '0;
`endif
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mbf_stream_checker.sv
// Bench for mbf_stream_checker: table-driven sample vectors scored through an expected-result
// queue, plus hand-written timeout, mid-run reset and counter saturation sequences.
module tb_mbf_stream_checker;

   localparam int NCH = 2, DW = 8, N_EXP = 4, AW = 3, CNT_W = 16, TMO = 20;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 start;
   logic [NCH-1:0]       in_valid;
   logic [NCH*DW-1:0]    in_data;
   logic                 ld_en;
   logic [2:0]           ld_ch;
   logic [AW-1:0]        ld_addr;
   logic [DW-1:0]        ld_data;
   logic                 busy, all_done, timed_out, pass;
   logic [NCH-1:0]       ch_done;
   logic [NCH*CNT_W-1:0] err_cnt, pass_cnt;

   // Saturation instance: one channel, five samples, 2-bit counters.
   logic       s_start;
   logic [0:0] s_valid;
   logic [7:0] s_data;
   logic       s_ld_en;
   logic [2:0] s_ld_ch;
   logic [2:0] s_ld_addr;
   logic [7:0] s_ld_data;
   logic       s_busy, s_all_done, s_timed_out, s_pass;
   logic [0:0] s_done;
   logic [1:0] s_err, s_pass_cnt;

`ifdef MBF_CHK_FIRSTERR_EN
   logic          fe_vld, s_fe_vld;
   logic [2:0]    fe_ch, s_fe_ch;
   logic [AW-1:0] fe_idx;
   logic [2:0]    s_fe_idx;
   logic [7:0]    fe_got, fe_exp, s_fe_got, s_fe_exp;
`endif

   mbf_stream_checker #(
      .NCH(NCH), .DW(DW), .N_EXP(N_EXP), .AW(AW), .CNT_W(CNT_W), .TIMEOUT(TMO)
   ) u_dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
      .ld_en(ld_en), .ld_ch(ld_ch), .ld_addr(ld_addr), .ld_data(ld_data),
      .busy(busy), .ch_done(ch_done), .all_done(all_done), .timed_out(timed_out),
      .pass(pass), .err_cnt(err_cnt), .pass_cnt(pass_cnt)
`ifdef MBF_CHK_FIRSTERR_EN
      , .first_err_vld(fe_vld), .first_err_ch(fe_ch), .first_err_idx(fe_idx),
      .first_err_got(fe_got), .first_err_exp(fe_exp)
`endif
   );

   mbf_stream_checker #(
      .NCH(1), .DW(8), .N_EXP(5), .AW(3), .CNT_W(2), .TIMEOUT(100)
   ) u_sat (
      .clk(clk), .reset(reset), .start(s_start), .in_valid(s_valid), .in_data(s_data),
      .ld_en(s_ld_en), .ld_ch(s_ld_ch), .ld_addr(s_ld_addr), .ld_data(s_ld_data),
      .busy(s_busy), .ch_done(s_done), .all_done(s_all_done), .timed_out(s_timed_out),
      .pass(s_pass), .err_cnt(s_err), .pass_cnt(s_pass_cnt)
`ifdef MBF_CHK_FIRSTERR_EN
      , .first_err_vld(s_fe_vld), .first_err_ch(s_fe_ch), .first_err_idx(s_fe_idx),
      .first_err_got(s_fe_got), .first_err_exp(s_fe_exp)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       v0;
      logic [7:0] d0;
      logic       v1;
      logic [7:0] d1;
      logic [1:0] done;
   } vec_t;

   typedef struct {
      int ch;
      bit match;
   } sb_t;

   vec_t       tv [15];
   logic [7:0] exp_tab [NCH][N_EXP];
   sb_t        sb_q [$];
   int         m_idx [NCH];
   bit         m_done [NCH];
   int         m_err [NCH];
   int         m_pass [NCH];
   int         n_checks = 0;
   int         n_fail = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int ch, input int addr, input logic [7:0] data);
      ld_en   = 1'b1;
      ld_ch   = 3'(ch);
      ld_addr = AW'(addr);
      ld_data = data;
      tick();
      ld_en   = 1'b0;
   endtask

   task automatic sb_start();
      for (int c = 0; c < NCH; c++) begin
         m_idx[c] = 0; m_done[c] = 1'b0; m_err[c] = 0; m_pass[c] = 0;
      end
      sb_q.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start busy", 32'(busy), 32'd1);
   endtask

   // Drive one row; expected outcomes are queued at drive time and retired after the edge.
   task automatic apply(input int r);
      logic       vv [NCH];
      logic [7:0] dd [NCH];
      sb_t        it;
      vv[0] = tv[r].v0; dd[0] = tv[r].d0;
      vv[1] = tv[r].v1; dd[1] = tv[r].d1;
      in_valid = {vv[1], vv[0]};
      in_data  = {dd[1], dd[0]};
      for (int c = 0; c < NCH; c++) begin
         if (vv[c] && !m_done[c]) begin
            it.ch    = c;
            it.match = (dd[c] == exp_tab[c][m_idx[c]]);
            sb_q.push_back(it);
            if (m_idx[c] == N_EXP - 1) m_done[c] = 1'b1;
            else                       m_idx[c]++;
         end
      end
      tick();
      in_valid = '0;
      while (sb_q.size() > 0) begin
         it = sb_q.pop_front();
         if (it.match) m_pass[it.ch]++;
         else          m_err[it.ch]++;
      end
      check($sformatf("row%0d ch_done", r), 32'(ch_done), 32'(tv[r].done));
      for (int c = 0; c < NCH; c++) begin
         check($sformatf("row%0d err_cnt%0d", r, c), 32'(err_cnt[c*CNT_W +: CNT_W]), 32'(m_err[c]));
         check($sformatf("row%0d pass_cnt%0d", r, c), 32'(pass_cnt[c*CNT_W +: CNT_W]), 32'(m_pass[c]));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < N_EXP; i++) begin
         exp_tab[0][i] = 8'((i + 1) * 16);
         exp_tab[1][i] = 8'(i + 1);
      end
      // Clean run, then an extra valid after completion.
      tv[0]  = '{1'b1, 8'h10, 1'b1, 8'h01, 2'b00};
      tv[1]  = '{1'b1, 8'h20, 1'b1, 8'h02, 2'b00};
      tv[2]  = '{1'b1, 8'h30, 1'b1, 8'h03, 2'b00};
      tv[3]  = '{1'b1, 8'h40, 1'b1, 8'h04, 2'b11};
      tv[4]  = '{1'b1, 8'h10, 1'b1, 8'h01, 2'b11};
      // Mismatches on ch0 sample 0 and ch1 sample 2.
      tv[5]  = '{1'b1, 8'h11, 1'b1, 8'h01, 2'b00};
      tv[6]  = '{1'b1, 8'h20, 1'b1, 8'h02, 2'b00};
      tv[7]  = '{1'b1, 8'h30, 1'b1, 8'hFF, 2'b00};
      tv[8]  = '{1'b1, 8'h40, 1'b1, 8'h04, 2'b11};
      tv[9]  = '{1'b1, 8'h99, 1'b1, 8'h99, 2'b11};
      // Only ch0 fed, then an extra ch0 valid after it is done.
      tv[10] = '{1'b1, 8'h10, 1'b0, 8'h00, 2'b00};
      tv[11] = '{1'b1, 8'h20, 1'b0, 8'h00, 2'b00};
      tv[12] = '{1'b1, 8'h30, 1'b0, 8'h00, 2'b00};
      tv[13] = '{1'b1, 8'h40, 1'b0, 8'h00, 2'b01};
      tv[14] = '{1'b1, 8'h10, 1'b0, 8'h00, 2'b01};

      reset = 1'b1; start = 1'b0; in_valid = '0; in_data = '0;
      ld_en = 1'b0; ld_ch = '0; ld_addr = '0; ld_data = '0;
      s_start = 1'b0; s_valid = '0; s_data = '0;
      s_ld_en = 1'b0; s_ld_ch = '0; s_ld_addr = '0; s_ld_data = '0;
      repeat (2) tick();
      check("reset busy", 32'(busy), 32'd0);
      check("reset ch_done", 32'(ch_done), 32'd0);
      check("reset all_done", 32'(all_done), 32'd0);
      check("reset timed_out", 32'(timed_out), 32'd0);
      check("reset pass", 32'(pass), 32'd0);
      check("reset err_cnt", err_cnt, 32'd0);
      check("reset pass_cnt", pass_cnt, 32'd0);
      reset = 1'b0;
      tick();

      for (int c = 0; c < NCH; c++)
         for (int i = 0; i < N_EXP; i++) load(c, i, exp_tab[c][i]);
      // Out-of-range writes that would alias real entries if not dropped.
      load(2, 1, 8'hEE);
      load(0, 4, 8'hEE);
      load(1, 7, 8'hEE);
      s_ld_en = 1'b1; s_ld_ch = 3'd0; s_ld_data = 8'h00;
      for (int i = 0; i < 5; i++) begin
         s_ld_addr = 3'(i);
         tick();
      end
      s_ld_en = 1'b0;

      // Clean run.
      sb_start();
      for (int r = 0; r <= 3; r++) apply(r);
      check("clean all_done early", 32'(all_done), 32'd0);
      apply(4);
      check("clean all_done", 32'(all_done), 32'd1);
      check("clean pass", 32'(pass), 32'd1);
      check("clean busy", 32'(busy), 32'd0);
      check("clean timed_out", 32'(timed_out), 32'd0);

      // Run with mismatches.
      sb_start();
      for (int r = 5; r <= 9; r++) apply(r);
      check("err all_done", 32'(all_done), 32'd1);
      check("err pass", 32'(pass), 32'd0);
      check("err err_cnt0", 32'(err_cnt[15:0]), 32'd1);
      check("err err_cnt1", 32'(err_cnt[31:16]), 32'd1);
`ifdef MBF_CHK_FIRSTERR_EN
      check("first_err_vld", 32'(fe_vld), 32'd1);
      check("first_err_ch", 32'(fe_ch), 32'd0);
      check("first_err_idx", 32'(fe_idx), 32'd0);
      check("first_err_got", 32'(fe_got), 32'h11);
      check("first_err_exp", 32'(fe_exp), 32'h10);
`endif

      // Timeout: only ch0 completes; TMO expected after exactly TMO cycles in RUN.
      sb_start();
      for (int r = 10; r <= 14; r++) apply(r);
      repeat (TMO - 6) tick();
      check("tmo timed_out early", 32'(timed_out), 32'd0);
      check("tmo busy early", 32'(busy), 32'd1);
      tick();
      check("tmo timed_out", 32'(timed_out), 32'd1);
      check("tmo busy", 32'(busy), 32'd0);
      check("tmo all_done", 32'(all_done), 32'd0);
      check("tmo ch_done", 32'(ch_done), 32'b01);
      check("tmo pass", 32'(pass), 32'd0);
      check("tmo pass_cnt0", 32'(pass_cnt[15:0]), 32'd4);

      // Writes attempted during RUN, then an asynchronous reset mid-run.
      sb_start();
      ld_en = 1'b1; ld_ch = 3'd0; ld_addr = 3'd2; ld_data = 8'hEE;
      apply(0);
      ld_ch = 3'd1; ld_addr = 3'd3;
      apply(1);
      ld_en = 1'b0;
      reset = 1'b1;
      #1;
      check("abort busy", 32'(busy), 32'd0);
      check("abort ch_done", 32'(ch_done), 32'd0);
      check("abort pass_cnt", pass_cnt, 32'd0);
      tick();
      reset = 1'b0;
      tick();
      sb_start();
      for (int r = 0; r <= 4; r++) apply(r);
      check("rerun all_done", 32'(all_done), 32'd1);
      check("rerun pass", 32'(pass), 32'd1);

      // Counter saturation: five mismatches into a 2-bit counter.
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         s_valid = 1'b1; s_data = 8'hAA;
         tick();
         s_valid = 1'b0;
         check($sformatf("sat err_cnt k%0d", k), 32'(s_err), (k + 1 > 3) ? 32'd3 : 32'(k + 1));
         check($sformatf("sat pass_cnt k%0d", k), 32'(s_pass_cnt), 32'd0);
      end
      check("sat ch_done", 32'(s_done), 32'd1);
      tick();
      check("sat all_done", 32'(s_all_done), 32'd1);
      check("sat pass", 32'(s_pass), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
